bpu_update_queue: RTL and testbench

- Collects commit-time branch resolution records from up to NRET retire slots per cycle and serialises them, in program order, onto the BPU's single-entry predictor update port.
- Sits between the commit stage and the BPU.
- Uses an in-order multi-push / single-pop FIFO with conservative backpressure to commit.
- Has no flush input: committed updates are architectural and are never discarded.

---
 rtl/bpu_update_queue.sv | 99 +++++++++
 tb/tb_bpu_update_queue.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/bpu_update_queue.sv
// bpu_update_queue: in-order multi-push/single-pop queue of commit-time branch updates feeding the BPU
module bpu_update_queue #(
   parameter int NRET  = 4,
   parameter int PLEN  = 32,
   parameter int DEPTH = 8
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic [NRET-1:0]             commit_valid_i,
   input  logic [NRET-1:0]             commit_is_branch_i,
   input  logic [NRET*PLEN-1:0]        commit_pc_i,
   input  logic [NRET-1:0]             commit_is_cond_i,
   input  logic [NRET-1:0]             commit_taken_i,
   input  logic [NRET*PLEN-1:0]        commit_target_i,
   input  logic [NRET-1:0]             commit_is_call_i,
   input  logic [NRET-1:0]             commit_is_ret_i,
   output logic                        ready_o,
   output logic                        update_valid_o,
   output logic [PLEN-1:0]             update_pc_o,
   output logic                        update_is_cond_o,
   output logic                        update_taken_o,
   output logic [PLEN-1:0]             update_target_o,
   output logic                        update_is_call_o,
   output logic                        update_is_ret_o,
   output logic [$clog2(DEPTH+1)-1:0]  count_o,
   output logic [31:0]                 stall_cnt_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   typedef struct packed {
      logic [PLEN-1:0] pc;
      logic [PLEN-1:0] target;
      logic            is_cond;
      logic            taken;
      logic            is_call;
      logic            is_ret;
   } rec_t;

   rec_t [DEPTH-1:0] ent_q, ent_d;
   logic [PW-1:0]    head_q, head_d, tail_q, tail_d, wptr;
   logic [CW-1:0]    count_q, count_d, k;
   logic [31:0]      stall_q, stall_d;
   logic [NRET-1:0]  elig;
   logic             pop;

   assign ready_o          = (CW'(DEPTH) - count_q) >= CW'(NRET);
   assign pop              = count_q != '0;
   assign update_valid_o   = pop;
   assign update_pc_o      = ent_q[head_q].pc;
   assign update_is_cond_o = ent_q[head_q].is_cond;
   assign update_taken_o   = ent_q[head_q].taken;
   assign update_target_o  = ent_q[head_q].target;
   assign update_is_call_o = ent_q[head_q].is_call;
   assign update_is_ret_o  = ent_q[head_q].is_ret;
   assign count_o          = count_q;
   assign stall_cnt_o      = stall_q;

   // compact eligible slots onto the tail, pop the head, and track occupancy and stalls
   always_comb begin
      ent_d = ent_q;
      elig  = ready_o ? (commit_valid_i & commit_is_branch_i) : '0;
      wptr  = tail_q;
      k     = '0;
      for (int i = 0; i < NRET; i++) begin
         if (elig[i]) begin
            ent_d[wptr].pc      = commit_pc_i[i*PLEN +: PLEN];
            ent_d[wptr].target  = commit_target_i[i*PLEN +: PLEN];
            ent_d[wptr].is_cond = commit_is_cond_i[i];
            ent_d[wptr].taken   = commit_taken_i[i];
            ent_d[wptr].is_call = commit_is_call_i[i];
            ent_d[wptr].is_ret  = commit_is_ret_i[i];
            wptr = wptr + 1'b1;
            k    = k + 1'b1;
         end
      end
      tail_d  = wptr;
      head_d  = pop ? head_q + 1'b1 : head_q;
      count_d = count_q + k - {{(CW-1){1'b0}}, pop};
      stall_d = (!ready_o && |(commit_valid_i & commit_is_branch_i) && stall_q != '1) ? stall_q + 32'd1 : stall_q;
   end

   // state registers; reset discards every queued record at once
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ent_q   <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         stall_q <= '0;
      end else begin
         ent_q   <= ent_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         stall_q <= stall_d;
      end
   end
endmodule

// File: tb/tb_bpu_update_queue.sv
// tb_bpu_update_queue: directed and randomized checks of bpu_update_queue against a queue-based model
module tb_bpu_update_queue;
   localparam int NRET = 4, PLEN = 32, DEPTH = 8;

   logic clk_i = 1'b0, rst_i = 1'b1;
   logic [NRET-1:0] cv, cb, cc, ct, cca, cr;
   logic [NRET*PLEN-1:0] cpc, ctg;
   logic ready_o, update_valid_o, update_is_cond_o, update_taken_o, update_is_call_o, update_is_ret_o;
   logic [PLEN-1:0] update_pc_o, update_target_o;
   logic [$clog2(DEPTH+1)-1:0] count_o;
   logic [31:0] stall_cnt_o;

   typedef struct {
      logic [31:0] pc, tgt;
      logic c, t, ca, r;
   } rec_t;

   rec_t mq[$];
   logic [31:0] mstall = 0;
   int nchk = 0, nerr = 0;

   bpu_update_queue dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .commit_valid_i(cv), .commit_is_branch_i(cb), .commit_pc_i(cpc),
      .commit_is_cond_i(cc), .commit_taken_i(ct), .commit_target_i(ctg),
      .commit_is_call_i(cca), .commit_is_ret_i(cr),
      .ready_o(ready_o), .update_valid_o(update_valid_o), .update_pc_o(update_pc_o),
      .update_is_cond_o(update_is_cond_o), .update_taken_o(update_taken_o),
      .update_target_o(update_target_o), .update_is_call_o(update_is_call_o),
      .update_is_ret_o(update_is_ret_o), .count_o(count_o), .stall_cnt_o(stall_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit mrdy();
      return (DEPTH - mq.size()) >= NRET;
   endfunction

   task automatic clr();
      cv = '0; cb = '0; cc = '0; ct = '0; cca = '0; cr = '0; cpc = '0; ctg = '0;
   endtask

   task automatic set_slot(input int i, input bit v, input bit b, input logic [31:0] pc,
                           input bit c, input bit t, input logic [31:0] tg, input bit ca, input bit r);
      cv[i] = v; cb[i] = b; cpc[i*PLEN +: PLEN] = pc; cc[i] = c; ct[i] = t;
      ctg[i*PLEN +: PLEN] = tg; cca[i] = ca; cr[i] = r;
   endtask

   task automatic compare();
      chk("valid", update_valid_o, mq.size() != 0);
      chk("count", count_o, mq.size());
      chk("ready", ready_o, mrdy());
      chk("stall", stall_cnt_o, mstall);
      if (mq.size() != 0) begin
         chk("pc", update_pc_o, mq[0].pc);
         chk("target", update_target_o, mq[0].tgt);
         chk("flags", {update_is_cond_o, update_taken_o, update_is_call_o, update_is_ret_o},
             {mq[0].c, mq[0].t, mq[0].ca, mq[0].r});
      end
   endtask

   task automatic step();
      bit rdy;
      rec_t r;
      rdy = mrdy();
      if (mq.size() != 0) void'(mq.pop_front());
      for (int i = 0; i < NRET; i++)
         if (rdy && cv[i] && cb[i]) begin
            r.pc = cpc[i*PLEN +: PLEN]; r.tgt = ctg[i*PLEN +: PLEN];
            r.c = cc[i]; r.t = ct[i]; r.ca = cca[i]; r.r = cr[i];
            mq.push_back(r);
         end
      if (!rdy && |(cv & cb) && mstall != 32'hFFFF_FFFF) mstall++;
      @(posedge clk_i);
      @(negedge clk_i);
      compare();
   endtask

   initial begin
      int g;
      int exp_cnt[6] = '{4, 7, 6, 5, 4, 7};
      clr();
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;
      #1;
      chk("rst_valid", update_valid_o, 0);
      chk("rst_count", count_o, 0);
      chk("rst_ready", ready_o, 1);
      chk("rst_stall", stall_cnt_o, 0);
      chk("rst_fields", {update_pc_o, update_target_o, update_is_cond_o, update_taken_o,
                         update_is_call_o, update_is_ret_o}, 0);
      @(negedge clk_i);

      set_slot(2, 1, 1, 32'h8000_0010, 1, 1, 32'h8000_0000, 0, 0);
      step();
      chk("single_pc", update_pc_o, 32'h8000_0010);
      chk("single_tgt", update_target_o, 32'h8000_0000);
      chk("single_ct", {update_valid_o, update_is_cond_o, update_taken_o}, 3'b111);
      clr();
      step();
      chk("single_empty", {update_valid_o, count_o}, 0);

      for (int i = 0; i < NRET; i++) set_slot(i, 1, i != 2, 32'h100 + i*4, 0, 0, 32'h200, 0, 0);
      step();
      chk("cmp_count", count_o, 3);
      chk("cmp_pc0", update_pc_o, 32'h100);
      clr();
      step();
      chk("cmp_pc1", update_pc_o, 32'h104);
      step();
      chk("cmp_pc3", update_pc_o, 32'h10C);
      step();

      g = 0;
      for (int c = 0; c < 6; c++) begin
         if (mrdy()) begin
            clr();
            if (g < 3)
               for (int i = 0; i < NRET; i++)
                  set_slot(i, 1, 1, 32'h1000 + g*16 + i*4, i[0], i[1], 32'h2000 + g, i == 3, i == 1);
            if (g < 3) g++;
         end
         step();
         chk("bp_count", count_o, exp_cnt[c]);
      end
      chk("bp_stall", stall_cnt_o, 3);
      clr();
      repeat (8) step();

      for (int c = 0; c < 20; c++) begin
         clr();
         set_slot($urandom_range(0, NRET-1), 1, 1, c*4, 1, c[0], 32'h4000, 0, 0);
         step();
         chk("wrap_pc", update_pc_o, c*4);
         chk("wrap_cnt_le1", count_o <= 1, 1);
      end
      clr();
      step();

      for (int c = 0; c < 300; c++) begin
         if (mrdy()) begin
            cv = NRET'($urandom) | NRET'($urandom);
            cb = NRET'($urandom) | NRET'($urandom);
            cc = NRET'($urandom); ct = NRET'($urandom);
            cca = NRET'($urandom); cr = NRET'($urandom);
            for (int i = 0; i < NRET; i++) begin
               cpc[i*PLEN +: PLEN] = $urandom;
               ctg[i*PLEN +: PLEN] = $urandom;
            end
         end
         #1;
         chk("ready_comb", ready_o, mrdy());
         step();
      end
      clr();
      repeat (10) step();

      for (int i = 0; i < NRET; i++) set_slot(i, 1, 1, 32'h3000 + i*4, 0, 1, 32'h3100, 0, 0);
      step();
      clr();
      set_slot(0, 1, 1, 32'h3010, 0, 0, 32'h0, 0, 1);
      set_slot(3, 1, 1, 32'h3014, 1, 0, 32'h0, 1, 0);
      step();
      chk("ar_count5", count_o, 5);
      clr();
      #2 rst_i = 1'b1;
      #1;
      chk("ar_valid", update_valid_o, 0);
      chk("ar_count", count_o, 0);
      mq.delete();
      mstall = 0;
      #1 rst_i = 1'b0;
      @(negedge clk_i);
      compare();
      set_slot(1, 1, 1, 32'h5000, 1, 0, 32'h5100, 0, 0);
      step();
      chk("ar_push_valid", update_valid_o, 1);
      chk("ar_push_pc", update_pc_o, 32'h5000);
      clr();
      step();

      $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
      $finish;
   end
endmodule
